// File: rtl/he_mem_pkg.sv
// he_mem_pkg: shared types and constants for the HE memory responder.
// Supplies a default BIT_WIDTH when he_headers.sv has not defined one.
// Optional feature macro: HE_MEM_STALL_EN (random extra wait cycles via LFSR).
`ifndef BIT_WIDTH
`define BIT_WIDTH 32
`endif
package he_mem_pkg;
   typedef enum logic [1:0] {IDLE, WAIT, RESP} port_state_e;
   localparam int LAT_BITS = 4;
   localparam logic [7:0] LFSR_SEED = 8'hA5;
   // Fibonacci taps 8,6,5,4 -> bits 7,5,4,3
   localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;
   function automatic logic [7:0] lfsr_next(input logic [7:0] s);
      return {s[6:0], ^(s & LFSR_TAPS)};
   endfunction
endpackage

// File: rtl/he_mem_port_timer.sv
// he_mem_port_timer: one port's IDLE->WAIT->RESP FSM with latency countdown.
// Ports: clk, rst (async active-low), req_i request level, lat_i wait cycles,
//        acc_o accept strobe (IDLE and req_i), resp_o registered response pulse.
module he_mem_port_timer
   import he_mem_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              req_i,
   input  logic [LAT_BITS:0] lat_i,
   output logic              acc_o,
   output logic              resp_o
);
   port_state_e       state_q;
   logic [LAT_BITS:0] cnt_q;
   assign acc_o = (state_q == IDLE) && req_i;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         resp_o  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (req_i) begin
               // zero latency skips WAIT entirely
               state_q <= (lat_i == '0) ? RESP : WAIT;
               resp_o  <= (lat_i == '0);
               cnt_q   <= (lat_i == '0) ? '0 : lat_i - 1'b1;
            end
            WAIT: if (cnt_q == '0) begin
               state_q <= RESP;
               resp_o  <= 1'b1;
            end else begin
               cnt_q <= cnt_q - 1'b1;
            end
            default: begin
               state_q <= IDLE;
               resp_o  <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: rtl/he_mem_responder.sv
// he_mem_responder: word-addressed memory model with independent latency-timed read/write ports.
// Ports: clk, rst (async active-low); read: mem_read_i, addr_read_i -> data_o, mem_resp_read_o;
//        write: mem_write_i, addr_write_i, data_i -> mem_resp_write_o; err_o sticky out-of-range.
// Optional feature macro: HE_MEM_STALL_EN adds lfsr[1:0] extra wait cycles per accepted request.
module he_mem_responder
   import he_mem_pkg::*;
#(
   parameter int BIT_WIDTH = `BIT_WIDTH,
   parameter int ADDR_BITS = 32,
   parameter int DEPTH     = 4096,
   parameter int READ_LAT  = 2,
   parameter int WRITE_LAT = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 mem_read_i,
   input  logic [ADDR_BITS-1:0] addr_read_i,
   output logic [BIT_WIDTH-1:0] data_o,
   output logic                 mem_resp_read_o,
   input  logic                 mem_write_i,
   input  logic [ADDR_BITS-1:0] addr_write_i,
   input  logic [BIT_WIDTH-1:0] data_i,
   output logic                 mem_resp_write_o,
   output logic                 err_o
);
   localparam int IDX = $clog2(DEPTH);
   localparam logic [LAT_BITS:0] RL = READ_LAT[LAT_BITS:0];
   localparam logic [LAT_BITS:0] WL = WRITE_LAT[LAT_BITS:0];
   logic [BIT_WIDTH-1:0] mem_q [DEPTH];
   logic [BIT_WIDTH-1:0] rd_q;
   logic                 rd_acc, wr_acc, rd_ok, wr_ok;
   logic [LAT_BITS:0]    rd_lat, wr_lat;
   assign rd_ok = (addr_read_i >> IDX) == '0;
   assign wr_ok = (addr_write_i >> IDX) == '0;
`ifdef HE_MEM_STALL_EN
   logic [7:0] lfsr_q;
   // both ports sample the same value; the LFSR steps once per accepting cycle
   assign rd_lat = RL + {{(LAT_BITS-1){1'b0}}, lfsr_q[1:0]};
   assign wr_lat = WL + {{(LAT_BITS-1){1'b0}}, lfsr_q[1:0]};
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) lfsr_q <= LFSR_SEED;
      else if (rd_acc || wr_acc) lfsr_q <= lfsr_next(lfsr_q);
   end
`else
   assign rd_lat = RL;
   assign wr_lat = WL;
`endif
   he_mem_port_timer u_rd (.clk(clk), .rst(rst), .req_i(mem_read_i), .lat_i(rd_lat),
                           .acc_o(rd_acc), .resp_o(mem_resp_read_o));
   he_mem_port_timer u_wr (.clk(clk), .rst(rst), .req_i(mem_write_i), .lat_i(wr_lat),
                           .acc_o(wr_acc), .resp_o(mem_resp_write_o));
   // array is deliberately not reset so contents survive rst
   always_ff @(posedge clk) begin
      if (wr_acc && wr_ok) mem_q[addr_write_i[IDX-1:0]] <= data_i;
   end
   // nonblocking read of mem_q gives read-before-write on same-edge accepts
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_q  <= '0;
         err_o <= 1'b0;
      end else begin
         if (rd_acc) rd_q <= rd_ok ? mem_q[addr_read_i[IDX-1:0]] : '0;
         if ((rd_acc && !rd_ok) || (wr_acc && !wr_ok)) err_o <= 1'b1;
      end
   end
   assign data_o = mem_resp_read_o ? rd_q : '0;
endmodule

// File: tb/tb_he_mem_responder.sv
// tb_he_mem_responder: directed self-checking bench for he_mem_responder (READ_LAT=2 and READ_LAT=0 instances).
module tb_he_mem_responder;
   localparam int DEPTH = 4096;
   localparam int RL = 2;
   localparam int WL = 1;
   logic        clk = 1'b0, rst = 1'b0;
   logic        rd_req = 1'b0, rd0_req = 1'b0, wr_req = 1'b0;
   logic [31:0] rd_addr = '0, wr_addr = '0, wdata = '0;
   logic [31:0] rdata, rdata0;
   logic        rresp, wresp, err, rresp0, wresp0, err0;
   int          checks = 0, failures = 0;
   logic [7:0]  lf_a = 8'hA5, lf_b = 8'hA5;

   always #5 clk = ~clk;

   he_mem_responder #(.BIT_WIDTH(32), .ADDR_BITS(32), .DEPTH(DEPTH), .READ_LAT(RL), .WRITE_LAT(WL)) dut (
      .clk(clk), .rst(rst), .mem_read_i(rd_req), .addr_read_i(rd_addr), .data_o(rdata),
      .mem_resp_read_o(rresp), .mem_write_i(wr_req), .addr_write_i(wr_addr), .data_i(wdata),
      .mem_resp_write_o(wresp), .err_o(err));

   he_mem_responder #(.BIT_WIDTH(32), .ADDR_BITS(32), .DEPTH(DEPTH), .READ_LAT(0), .WRITE_LAT(WL)) dut0 (
      .clk(clk), .rst(rst), .mem_read_i(rd0_req), .addr_read_i(rd_addr), .data_o(rdata0),
      .mem_resp_read_o(rresp0), .mem_write_i(wr_req), .addr_write_i(wr_addr), .data_i(wdata),
      .mem_resp_write_o(wresp0), .err_o(err0));

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h want %0h", tag, act, exp);
      end
   endtask

   function automatic logic [7:0] lf_step(input logic [7:0] s);
      return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // extra stall cycles the model expects for an accept on dut (a) / dut0 (b)
   task automatic take(input bit a, input bit b, output int ea, output int eb);
      ea = 0;
      eb = 0;
`ifdef HE_MEM_STALL_EN
      if (a) begin ea = int'(lf_a[1:0]); lf_a = lf_step(lf_a); end
      if (b) begin eb = int'(lf_b[1:0]); lf_b = lf_step(lf_b); end
`else
      if (a && b && lf_a != lf_b) ea = 0;
`endif
   endtask

   task automatic run(input bit rd, input bit wr, input logic [31:0] ra, input logic [31:0] wa,
                      input logic [31:0] wd, input logic [31:0] exp);
      int ea, eb, n;
      bit rs, ws;
      take(rd || wr, wr, ea, eb);
      rd_req = rd; wr_req = wr; rd_addr = ra; wr_addr = wa; wdata = wd;
      rs = !rd;
      ws = !wr;
      tick;
      rd_req = 1'b0;
      wr_req = 1'b0;
      n = 1;
      while (!(rs && ws) && n <= 24) begin
         if (!rs) begin
            if (rresp) begin
               chk("rd_lat", n, RL + ea + 1);
               chk("rd_data", rdata, exp);
               rs = 1;
            end else chk("rd_idle_zero", rdata, 0);
         end
         if (!ws && wresp) begin
            chk("wr_lat", n, WL + ea + 1);
            ws = 1;
         end
         if (!(rs && ws)) begin tick; n++; end
      end
      if (!rs) chk("rd_timeout", 0, 1);
      if (!ws) chk("wr_timeout", 0, 1);
      tick;
      chk("resp_after", {rresp, wresp, rdata}, 0);
      repeat (6) tick;
   endtask

   task automatic burst;
      int t, prev, w, ea, eb;
      take(0, 1, ea, eb);
      rd0_req = 1'b1;
      rd_addr = 0;
      t = 0;
      prev = 0;
      for (int i = 0; i < 4; i++) begin
         w = 0;
         do begin tick; t++; w++; end while (!rresp0 && w < 12);
         chk("b_resp", rresp0, 1);
         chk("b_data", rdata0, 32'h1000 + i * 3);
         chk("b_gap", t - prev, (i == 0) ? 1 + eb : 2 + eb);
         prev = t;
         rd_addr = i + 1;
         if (i < 3) take(0, 1, ea, eb);
         else rd0_req = 1'b0;
      end
      tick;
      chk("b_after", {rresp0, rdata0}, 0);
      repeat (4) tick;
   endtask

   initial begin
      int ea, eb;
      repeat (2) tick;
      chk("rst_outs", {rresp, wresp, rdata, err, rresp0, wresp0, rdata0, err0}, 0);
      rst = 1'b1;
      tick;
      run(0, 1, 0, 5, 32'hDEAD_BEEF, 0);
      run(1, 0, 5, 0, 0, 32'hDEAD_BEEF);
      for (int i = 0; i < 4; i++) run(0, 1, 0, i, 32'h1000 + i * 3, 0);
      burst;
      chk("err_clear", err, 0);
      run(1, 0, DEPTH + 1, 0, 0, 0);
      chk("err_rd_oor", err, 1);
      chk("err0_untouched", err0, 0);
      run(0, 1, 0, DEPTH + 3, 32'h55, 0);
      chk("err0_wr_oor", err0, 1);
      run(1, 0, 3, 0, 0, 32'h1009);
      run(0, 1, 0, 7, 32'h11, 0);
      run(1, 1, 7, 7, 32'h22, 32'h11);
      run(1, 0, 7, 0, 0, 32'h22);
      chk("err_sticky", err, 1);
      run(0, 1, 0, 9, 32'h99, 0);
      take(1, 0, ea, eb);
      rd_req = 1'b1;
      rd_addr = 9;
      tick;
      rd_req = 1'b0;
      rst = 1'b0;
      #1;
      chk("rst_mid_wait", {rresp, wresp, rdata, err}, 0);
      repeat (2) begin tick; chk("rst_hold", {rresp, rdata, err, err0}, 0); end
      rst = 1'b1;
      lf_a = 8'hA5;
      lf_b = 8'hA5;
      repeat (5) begin tick; chk("no_resp_after_rst", {rresp, rdata}, 0); end
      run(1, 0, 9, 0, 0, 32'h99);
      run(1, 0, 5, 0, 0, 32'hDEAD_BEEF);
`ifdef HE_MEM_STALL_EN
      for (int i = 0; i < 16; i++) run(1, 0, 5, 0, 0, 32'hDEAD_BEEF);
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
endmodule
